// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S frame buffer.
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic {
    WAIT_L,
    WAIT_R
  } pair_state_t;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_frame_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_frame_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one extra wrap bit
// so full/empty/count need no separate occupancy register.
module i2s_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/i2s_frame_buffer.sv
// Pairs channel-tagged I2S samples into stereo frames and buffers them.
// Optional I2S_MONO_MIX_EN adds mono_out = (left + right) >>> 1 of the head frame.
module i2s_frame_buffer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                sample_ws,
  input  logic                frame_ready,
  input  logic                clear_ovf,
  output logic [SAMPLE_W-1:0] frame_left,
  output logic [SAMPLE_W-1:0] frame_right,
  output logic                frame_valid,
  output logic [CNT_W-1:0]    frame_count,
  output logic                overflow,
`ifdef I2S_MONO_MIX_EN
  output logic [SAMPLE_W-1:0] mono_out,
`endif
  output logic                sync_err
);

  pair_state_t             state;
  pair_state_t             next_state;
  logic [SAMPLE_W-1:0]     hold_left;
  logic                    load_left;
  logic                    push_req;
  logic                    order_err;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [2*SAMPLE_W-1:0]   head;
  logic                    drop;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= WAIT_L;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_left  = 1'b0;
    push_req   = 1'b0;
    order_err  = 1'b0;
    if (sample_valid) begin
      unique case (state)
        WAIT_L: begin
          if (sample_ws == CH_LEFT) begin
            load_left  = 1'b1;
            next_state = WAIT_R;
          end else begin
            order_err = 1'b1;
          end
        end
        WAIT_R: begin
          if (sample_ws == CH_RIGHT) begin
            push_req   = 1'b1;
            next_state = WAIT_L;
          end else begin
            load_left = 1'b1;
            order_err = 1'b1;
          end
        end
        default: next_state = WAIT_L;
      endcase
    end
  end

  // A full FIFO is never empty, so frame_ready alone decides whether a pop frees room.
  assign drop = push_req && fifo_full && !frame_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_left <= '0;
      sync_err  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load_left) hold_left <= sample_in;
      sync_err <= order_err;
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  i2s_frame_fifo #(
    .WIDTH (2*SAMPLE_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push_req),
    .pop   (frame_ready),
    .din   ({hold_left, sample_in}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (frame_count)
  );

  // Gating keeps the outputs at zero out of reset, before storage holds valid data.
  assign frame_valid = !fifo_empty;
  assign frame_left  = fifo_empty ? '0 : head[2*SAMPLE_W-1:SAMPLE_W];
  assign frame_right = fifo_empty ? '0 : head[SAMPLE_W-1:0];

`ifdef I2S_MONO_MIX_EN
  logic signed [SAMPLE_W:0] mono_sum;
  assign mono_sum = $signed({frame_left[SAMPLE_W-1], frame_left})
                  + $signed({frame_right[SAMPLE_W-1], frame_right});
  assign mono_out = mono_sum[SAMPLE_W:1];
`endif

endmodule

// File: tb/tb_i2s_frame_buffer.sv
// Directed scoreboard bench for i2s_frame_buffer (covers I2S_MONO_MIX_EN when defined).
module tb_i2s_frame_buffer;

  localparam int SW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [SW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ws;
  logic          frame_ready;
  logic          clear_ovf;
  logic [SW-1:0] frame_left;
  logic [SW-1:0] frame_right;
  logic          frame_valid;
  logic [CW-1:0] frame_count;
  logic          overflow;
  logic          sync_err;
`ifdef I2S_MONO_MIX_EN
  logic [SW-1:0] mono_out;
`endif

  i2s_frame_buffer #(
    .SAMPLE_W (SW),
    .DEPTH    (DEPTH),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ws    (sample_ws),
    .frame_ready  (frame_ready),
    .clear_ovf    (clear_ovf),
    .frame_left   (frame_left),
    .frame_right  (frame_right),
    .frame_valid  (frame_valid),
    .frame_count  (frame_count),
    .overflow     (overflow),
`ifdef I2S_MONO_MIX_EN
    .mono_out     (mono_out),
`endif
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [2*SW-1:0] q[$];
  logic            m_state;
  logic [SW-1:0]   m_left;
  logic            m_ovf;
  logic            m_sync;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic post_check(input string tag);
    logic signed [SW:0] s;
    chk({tag, ".valid"}, 32'(frame_valid), 32'(q.size() > 0));
    chk({tag, ".count"}, 32'(frame_count), 32'(q.size()));
    chk({tag, ".ovf"},   32'(overflow),    32'(m_ovf));
    chk({tag, ".sync"},  32'(sync_err),    32'(m_sync));
    if (q.size() > 0) begin
      chk({tag, ".head"}, {frame_left, frame_right}, q[0]);
`ifdef I2S_MONO_MIX_EN
      s = $signed({q[0][2*SW-1], q[0][2*SW-1:SW]}) + $signed({q[0][SW-1], q[0][SW-1:0]});
      chk({tag, ".mono"}, 32'(mono_out), 32'(s[SW:1]));
`endif
    end
  endtask

  // One clock of stimulus, applied at a falling edge; model updated alongside.
  task automatic drive(input string tag, input logic v, input logic ws,
                       input logic [SW-1:0] d, input logic rdy, input logic clr);
    logic pop, pushf, drop;
    sample_valid = v; sample_ws = ws; sample_in = d;
    frame_ready = rdy; clear_ovf = clr;
    pop = rdy && (q.size() > 0);
    pushf = 1'b0; drop = 1'b0; m_sync = 1'b0;
    if (v) begin
      if (!m_state) begin
        if (!ws) begin m_left = d; m_state = 1'b1; end
        else m_sync = 1'b1;
      end else begin
        if (ws) begin
          m_state = 1'b0;
          if (q.size() < DEPTH || pop) pushf = 1'b1;
          else drop = 1'b1;
        end else begin
          m_left = d; m_sync = 1'b1;
        end
      end
    end
    if (pop)   void'(q.pop_front());
    if (pushf) q.push_back({m_left, d});
    if (drop)      m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
    @(negedge clk);
    sample_valid = 1'b0; frame_ready = 1'b0; clear_ovf = 1'b0;
    post_check(tag);
  endtask

  task automatic idle(input string tag, input logic rdy, input logic clr);
    drive(tag, 1'b0, 1'b0, '0, rdy, clr);
  endtask

  initial begin
    n_rst = 1'b0; sample_in = '0; sample_valid = 1'b0; sample_ws = 1'b0;
    frame_ready = 1'b0; clear_ovf = 1'b0;
    m_state = 1'b0; m_left = '0; m_ovf = 1'b0; m_sync = 1'b0;
    repeat (3) @(negedge clk);
    post_check("reset");
    chk("reset.left",  32'(frame_left),  32'h0);
    chk("reset.right", 32'(frame_right), 32'h0);
    n_rst = 1'b1;
    @(negedge clk);

    // basic pair and latency
    drive("l1234", 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
    drive("rabcd", 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0);
    idle("pop1", 1'b1, 1'b0);
    idle("empty_rdy", 1'b1, 1'b0);

    // right first
    drive("r0001", 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
    drive("l0002", 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
    drive("r0003", 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0);
    idle("pop2", 1'b1, 1'b0);

    // double left
    drive("l0010", 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
    drive("l0020", 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0);
    drive("r0030", 1'b1, 1'b1, 16'h0030, 1'b0, 1'b0);
    idle("pop3", 1'b1, 1'b0);

    // 9 frames into DEPTH=8, no consumer
    for (int i = 0; i < 9; i++) begin
      drive("fill_l", 1'b1, 1'b0, 16'h1000 + 16'(i), 1'b0, 1'b0);
      drive("fill_r", 1'b1, 1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
    end
    chk("fill.ovf_set", 32'(overflow), 32'h1);
    chk("fill.count8",  32'(frame_count), 32'(DEPTH));
    idle("clr1", 1'b0, 1'b1);
    chk("clr1.ovf", 32'(overflow), 32'h0);

    // clear and new overflow in the same cycle: set wins
    drive("swin_l", 1'b1, 1'b0, 16'h3000, 1'b0, 1'b0);
    drive("swin_r", 1'b1, 1'b1, 16'h3001, 1'b0, 1'b1);
    chk("swin.ovf", 32'(overflow), 32'h1);
    idle("clr2", 1'b0, 1'b1);

    // push while full with a pop in the same cycle, then stream with wrap
    drive("fp_l", 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0);
    drive("fp_r", 1'b1, 1'b1, 16'h5000, 1'b1, 1'b0);
    chk("fp.count8", 32'(frame_count), 32'(DEPTH));
    for (int i = 1; i < 8; i++) begin
      drive("wr_l", 1'b1, 1'b0, 16'h4000 + 16'(i), 1'b1, 1'b0);
      drive("wr_r", 1'b1, 1'b1, 16'h5000 + 16'(i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 10; i++) idle("drain", 1'b1, 1'b0);
    chk("drain.ovf", 32'(overflow), 32'h0);

    // mono mix corner values
    drive("m1l", 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    drive("m1r", 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b0);
`ifdef I2S_MONO_MIX_EN
    chk("mono.pos", 32'(mono_out), 32'h7FFF);
`endif
    idle("m1pop", 1'b1, 1'b0);
    drive("m2l", 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0);
    drive("m2r", 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b0);
`ifdef I2S_MONO_MIX_EN
    chk("mono.neg", 32'(mono_out), 32'hFFFF);
`endif
    idle("m2pop", 1'b1, 1'b0);

    // asynchronous reset mid-stream: 3 frames stored, FSM in WAIT_R
    for (int i = 0; i < 3; i++) begin
      drive("pre_l", 1'b1, 1'b0, 16'h6000 + 16'(i), 1'b0, 1'b0);
      drive("pre_r", 1'b1, 1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0);
    end
    drive("pre_wr", 1'b1, 1'b0, 16'h6666, 1'b0, 1'b0);
    chk("pre.count3", 32'(frame_count), 32'h3);
    #2 n_rst = 1'b0;
    #1;
    q.delete(); m_state = 1'b0; m_left = '0; m_ovf = 1'b0; m_sync = 1'b0;
    post_check("arst");
    chk("arst.left",  32'(frame_left),  32'h0);
    chk("arst.right", 32'(frame_right), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    drive("post_r", 1'b1, 1'b1, 16'h0BAD, 1'b0, 1'b0);
    idle("post_idle", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
